lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store unit that sits between the CPU execute stage and the data memory.
- Accepts one load or store request at a time through a valid/ready handshake.
- Drives the memory's word-aligned address, write-data and write-enable lines, and consumes its one-cycle-latency registered read data.
- Performs byte-lane extraction and sign/zero extension for loads, and read-modify-write merging for sub-word stores. Misaligned or out-of-range accesses are flagged.

Parameters:
- MEM_ADDR_BITS, 17: byte-address width of the physical data memory (128 KiB). A request address at or above 2**MEM_ADDR_BITS is a fault.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  zero-extend loads (lbu/lhu); ignored for word accesses and stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low bits are used for sub-word stores.
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  32  load result; 0 for stores and faults.
- resp_err  out  1  valid with resp_valid: misaligned, illegal size or out-of-range.
- mem_addr  out  32  word-aligned byte address to memory; bits [1:0] are always 0.
- mem_wdata  out  32  full word to write.
- mem_wen  out  1  memory write enable.
- mem_din  in  32  memory read word. Valid in the cycle after the memory samples mem_addr. Little-endian: byte addr+0 is in [7:0].

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; resp_valid 0; resp_rdata 0; resp_err 0; mem_addr 0; mem_wdata 0; mem_wen 0. req_ready is 0 in any cycle where rst is high.
- All mem_* and resp_* outputs are registered. req_ready = (state == IDLE) && !rst.
- Handshake: a request is accepted on the edge where req_valid && req_ready. All request fields are latched at that edge; the requester may change them afterwards. Cycle 0 is the accept cycle.
- Fault check at accept, with no memory access for any fault:
  - size 11;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr[31:MEM_ADDR_BITS] != 0.
- States:
  - IDLE: wait for a request.
    - Fault -> RESP with err = 1.
    - Word store -> WR.
    - Any other access -> RD.
  - RD: mem_addr = {addr[31:2], 2'b00}, mem_wen = 0. Go to WAIT.
  - WAIT: mem_din is valid.
    - Load: extract and extend, register the result, go to RESP.
    - Sub-word store: register the merged word in mem_wdata, go to WR.
  - WR: mem_wen = 1 for exactly this cycle. mem_wdata holds either req_wdata (word store) or the merged word. Go to RESP.
  - RESP: resp_valid = 1 for exactly one cycle. Go to IDLE.
- Latency from accept cycle 0 to the resp_valid cycle:
  - fault: cycle 1;
  - word store: WR in cycle 1, resp in cycle 2;
  - load: RD 1, WAIT 2, resp 3;
  - sub-word store: RD 1, WAIT 2, WR 3, resp 4.
- Next accept is possible in the cycle after RESP, so throughput is one request per (latency + 1) cycles.
- Load extraction:
  - byte: lane = addr[1:0], value = mem_din[8*lane+7 : 8*lane], sign-extended from bit 7 unless req_unsigned;
  - half: lane = addr[1], value = mem_din[16*lane+15 : 16*lane], sign-extended from bit 15 unless req_unsigned;
  - word: mem_din unchanged.
- Store merge:
  - byte: replace the addressed lane with wdata[7:0];
  - half: replace the addressed halfword with wdata[15:0];
  - other bytes are taken from mem_din.
- Idle outputs: mem_addr and mem_wdata hold their last values; mem_wen is 0 outside WR.
- resp_rdata and resp_err hold until the next RESP. They are only meaningful while resp_valid is high.
- Reset mid-operation: the FSM returns to IDLE at the sampling edge.
  - A write whose mem_wen is already high in the cycle rst is sampled completes at that edge.
  - No later mem_wen and no resp_valid are produced for the aborted request.
- req_valid outside IDLE is ignored; the request is not accepted.

Test Plan:
- Preload word 0x100 = 0x8899AABB. lb 0x101 -> resp_valid in cycle 3, rdata 0xFFFFFFAA, err 0. lbu 0x101 -> 0x000000AA.
- lh 0x102 -> 0xFFFF8899; lhu 0x102 -> 0x00008899. mem_addr = 0x100 and mem_wen = 0 throughout.
- sb 0x102, wdata 0x12345677, with word 0x100 = 0x8899AABB:
  - RD cycle 1, mem_wen = 1 only in cycle 3 with mem_wdata 0x8877AABB, resp in cycle 4;
  - a following lw 0x100 returns 0x8877AABB.
- sw 0x104, wdata 0xDEADBEEF -> mem_wen in cycle 1, mem_wdata 0xDEADBEEF, resp in cycle 2. Back-to-back req_valid is accepted again the cycle after resp.
- Faults, each giving resp in cycle 1 with err = 1, rdata 0 and mem_wen never asserted:
  - lw 0x102;
  - lh 0x101;
  - size 11;
  - lw 0x00020000.
- sb 0x100 with rst asserted in cycle 2 -> mem_wen never high, resp_valid never high. req_ready is 0 while rst is high and 1 the cycle after rst drops. The word at 0x100 is unchanged.

Source files
------------

// File: rtl/lsu_mem_master.sv
// Load/store unit: one request at a time, byte/half/word loads and stores against a 1-cycle-latency word memory.
// Latency accept->resp: fault 1, word store 2, load 3, sub-word store 4; req_ready low until the cycle after resp.
module lsu_mem_master #(
    parameter int MEM_ADDR_BITS = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    input  logic [31:0] mem_din
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_RESP
    } state_t;

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        req_fault;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign req_ready = (state == S_IDLE) && !rst;

    always_comb begin
        req_fault = 1'b0;
        if (req_size == 2'b11)
            req_fault = 1'b1;
        if (req_size == 2'b01 && req_addr[0])
            req_fault = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            req_fault = 1'b1;
        if (req_addr[31:MEM_ADDR_BITS] != '0)
            req_fault = 1'b1;
    end

    // Lane selection uses only the latched low address bits; mem_din is the word fetched in RD.
    always_comb begin
        ld_byte  = mem_din[{lane_q, 3'b000} +: 8];
        ld_half  = mem_din[{lane_q[1], 4'b0000} +: 16];
        load_val = mem_din;
        case (size_q)
            2'b00:   load_val = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
            2'b01:   load_val = {{16{ld_half[15] & ~uns_q}}, ld_half};
            default: load_val = mem_din;
        endcase
    end

    always_comb begin
        merged = mem_din;
        case (size_q)
            2'b00:   merged[{lane_q, 3'b000} +: 8]      = wdata_q[7:0];
            2'b01:   merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
            default: merged = mem_din;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= 16'h0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_wen    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    mem_wen <= 1'b0;
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        lane_q  <= req_addr[1:0];
                        wdata_q <= req_wdata[15:0];
                        if (req_fault) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                            state      <= S_RESP;
                        end else if (req_we && req_size == 2'b10) begin
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= req_wdata;
                            mem_wen   <= 1'b1;
                            state     <= S_WR;
                        end else begin
                            mem_addr <= {req_addr[31:2], 2'b00};
                            state    <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!we_q) begin
                        resp_rdata <= load_val;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        mem_wdata <= merged;
                        mem_wen   <= 1'b1;
                        state     <= S_WR;
                    end
                end
                S_WR: begin
                    mem_wen    <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                    state      <= S_RESP;
                end
                S_RESP: begin
                    resp_valid <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    mem_wen    <= 1'b0;
                    resp_valid <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: directed scenarios plus randomized traffic against a word-array reference model.
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_wen;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_din;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    // observations of the last issued request
    logic        o_ready0, o_resp_at_start, o_busy_ready, o_addr_bad, o_err;
    int          o_resp_cyc, o_wen_cnt, o_wen_cyc;
    logic [31:0] o_rdata, o_wen_dat;

    lsu_mem_master #(.MEM_ADDR_BITS(17)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_din(mem_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wen) mem[mem_addr[11:2]] <= mem_wdata;
        mem_din <= mem[mem_addr[11:2]];
    end

    // Drives one request, then keeps garbage on the request bus (valid high) while busy.
    task automatic issue(input logic we, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        o_ready0 = req_ready;
        o_resp_at_start = resp_valid;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = un;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        o_resp_cyc = -1; o_wen_cnt = 0; o_wen_cyc = -1; o_wen_dat = 32'h0;
        o_busy_ready = 1'b0; o_addr_bad = 1'b0; o_rdata = 32'h0; o_err = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (req_ready) o_busy_ready = 1'b1;
            if (mem_addr !== {a[31:2], 2'b00}) o_addr_bad = 1'b1;
            if (mem_wen) begin
                o_wen_cnt++; o_wen_cyc = c; o_wen_dat = mem_wdata;
            end
            if (resp_valid) begin
                o_resp_cyc = c; o_rdata = resp_rdata; o_err = resp_err;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp got %h/%b want 0/0", resp_rdata, resp_err); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wen !== 1'b0) begin errors++; $display("FAIL reset_mem got %h/%h/%b want 0", mem_addr, mem_wdata, mem_wen); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", req_ready); end
    endtask

    task automatic test_loads();
        logic [1:0]  sz [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
        logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad [4] = '{32'h101, 32'h101, 32'h102, 32'h102};
        logic [31:0] ex [4] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899};
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, sz[i], un[i], ad[i], 32'h0);
            checks++; if (o_resp_cyc != 3) begin errors++; $display("FAIL load%0d_latency got %0d want 3", i, o_resp_cyc); end
            checks++; if (o_rdata !== ex[i] || o_err !== 1'b0) begin errors++; $display("FAIL load%0d_data got %h/%b want %h/0", i, o_rdata, o_err, ex[i]); end
            checks++; if (o_wen_cnt != 0 || o_addr_bad) begin errors++; $display("FAIL load%0d_membus wen=%0d addr_bad=%b want 0/0", i, o_wen_cnt, o_addr_bad); end
        end
    endtask

    task automatic test_sub_store();
        issue(1'b1, 2'd0, 1'b0, 32'h102, 32'h12345677);
        ref_mem[32'h100 >> 2] = 32'h8877AABB;
        checks++; if (o_resp_cyc != 4) begin errors++; $display("FAIL sb_latency got %0d want 4", o_resp_cyc); end
        checks++; if (o_wen_cnt != 1 || o_wen_cyc != 3) begin errors++; $display("FAIL sb_wen got cnt=%0d cyc=%0d want 1/3", o_wen_cnt, o_wen_cyc); end
        checks++; if (o_wen_dat !== 32'h8877AABB) begin errors++; $display("FAIL sb_wdata got %h want 8877aabb", o_wen_dat); end
        checks++; if (o_rdata !== 32'h0 || o_err !== 1'b0 || o_addr_bad) begin errors++; $display("FAIL sb_resp got %h/%b addr_bad=%b want 0/0/0", o_rdata, o_err, o_addr_bad); end
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        checks++; if (o_rdata !== 32'h8877AABB || o_resp_cyc != 3) begin errors++; $display("FAIL lw_after_sb got %h@%0d want 8877aabb@3", o_rdata, o_resp_cyc); end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 2'd2, 1'b0, 32'h104, 32'hDEADBEEF);
        ref_mem[32'h104 >> 2] = 32'hDEADBEEF;
        checks++; if (o_wen_cnt != 1 || o_wen_cyc != 1 || o_wen_dat !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wen got cnt=%0d cyc=%0d dat=%h want 1/1/deadbeef", o_wen_cnt, o_wen_cyc, o_wen_dat); end
        checks++; if (o_resp_cyc != 2) begin errors++; $display("FAIL sw_latency got %0d want 2", o_resp_cyc); end
        issue(1'b1, 2'd2, 1'b0, 32'h108, 32'hCAFEF00D);
        ref_mem[32'h108 >> 2] = 32'hCAFEF00D;
        checks++; if (o_ready0 !== 1'b1 || o_resp_at_start !== 1'b0) begin errors++; $display("FAIL b2b_accept got ready=%b resp=%b want 1/0", o_ready0, o_resp_at_start); end
        checks++; if (o_resp_cyc != 2 || o_wen_cyc != 1) begin errors++; $display("FAIL b2b_timing got resp=%0d wen=%0d want 2/1", o_resp_cyc, o_wen_cyc); end
        issue(1'b0, 2'd2, 1'b0, 32'h104, 32'h0);
        checks++; if (o_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_after_sw got %h want deadbeef", o_rdata); end
    endtask

    task automatic test_faults();
        logic        we [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0]  sz [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
        logic [31:0] ad [4] = '{32'h102, 32'h101, 32'h100, 32'h00020000};
        for (int i = 0; i < 4; i++) begin
            issue(we[i], sz[i], 1'b0, ad[i], 32'h11223344);
            checks++; if (o_resp_cyc != 1) begin errors++; $display("FAIL fault%0d_latency got %0d want 1", i, o_resp_cyc); end
            checks++; if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_wen_cnt != 0) begin errors++; $display("FAIL fault%0d_resp got err=%b rdata=%h wen=%0d want 1/0/0", i, o_err, o_rdata, o_wen_cnt); end
        end
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h100; req_wdata = 32'h55;
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk); seen |= mem_wen | resp_valid;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk); seen |= mem_wen | resp_valid;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_c2 got %b want 0", req_ready); end
        @(posedge clk); #1;
        @(negedge clk); seen |= mem_wen | resp_valid;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_c3 got %b want 0", req_ready); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_after got %b want 1", req_ready); end
        for (int i = 0; i < 5; i++) begin
            seen |= mem_wen | resp_valid;
            @(negedge clk);
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_activity got %b want 0", seen); end
        checks++; if (mem[32'h100 >> 2] !== ref_mem[32'h100 >> 2]) begin errors++; $display("FAIL rstmid_word got %h want %h", mem[32'h100 >> 2], ref_mem[32'h100 >> 2]); end
    endtask

    task automatic test_random();
        int bad_words = 0;
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a, wd, w, v, mask, exp_rd, exp_wd;
            logic [1:0]  sz;
            logic        we, un, fault;
            int          sh, exp_cyc, exp_wen;
            a = $urandom_range(0, 4095);
            if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(17, 31));
            sz = 2'($urandom_range(0, 3));
            if (sz == 2'd3 && $urandom_range(0, 2) != 0) sz = 2'd2;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            we = 1'($urandom); un = 1'($urandom); wd = $urandom;
            fault = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 0) || (a >= 32'h20000);
            w = ref_mem[a[11:2]];
            sh = (sz == 2'd0) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
            mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
            exp_rd = 32'h0; exp_wd = 32'h0; exp_wen = 0;
            if (fault) exp_cyc = 1;
            else if (we) begin
                exp_wen = 1;
                exp_cyc = (sz == 2'd2) ? 2 : 4;
                exp_wd = (sz == 2'd2) ? wd : ((w & ~(mask << sh)) | ((wd & mask) << sh));
                ref_mem[a[11:2]] = exp_wd;
            end else begin
                exp_cyc = 3;
                v = (w >> sh) & mask;
                if (!un && sz == 2'd0 && v[7])  v = v | 32'hFFFFFF00;
                if (!un && sz == 2'd1 && v[15]) v = v | 32'hFFFF0000;
                exp_rd = (sz == 2'd2) ? w : v;
            end
            issue(we, sz, un, a, wd);
            checks++;
            if (o_resp_cyc != exp_cyc || o_err !== fault || o_rdata !== exp_rd || o_wen_cnt != exp_wen ||
                (exp_wen == 1 && (o_wen_cyc != exp_cyc - 1 || o_wen_dat !== exp_wd)) ||
                (!fault && o_addr_bad) || o_busy_ready || !o_ready0) begin
                errors++;
                $display("FAIL rand%0d a=%h sz=%0d we=%b got cyc=%0d err=%b rd=%h wen=%0d@%0d wd=%h want cyc=%0d err=%b rd=%h wen=%0d wd=%h",
                         n, a, sz, we, o_resp_cyc, o_err, o_rdata, o_wen_cnt, o_wen_cyc, o_wen_dat,
                         exp_cyc, fault, exp_rd, exp_wen, exp_wd);
            end
        end
        @(negedge clk);
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad_words++;
        checks++; if (bad_words != 0) begin errors++; $display("FAIL final_memory got %0d differing words want 0", bad_words); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        mem[32'h100 >> 2]     = 32'h8899AABB;
        ref_mem[32'h100 >> 2] = 32'h8899AABB;
        test_reset();
        test_loads();
        test_sub_store();
        test_back_to_back();
        test_faults();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
